// File: rtl/ica_dca_burst_responder_pkg.sv
// Shared types and defaults for the ICA/DCA burst responder.
package ica_dca_burst_responder_pkg;

  localparam int unsigned BurstWordsDef = 4;
  localparam int unsigned AddrWDef      = 22;
  localparam int unsigned NumClients    = 2;

  // Responder sequencing: arbitrate, hand off to memory, stream words, acknowledge.
  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StStream,
    StAck
  } resp_state_e;

  // One client request channel as seen by the responder.
  typedef struct packed {
    logic                as;
    logic [AddrWDef-1:0] address;
  } client_req_t;

endpackage

// File: rtl/ica_dca_burst_responder_rr_arbiter2.sv
// Two-way round-robin arbiter; the previous winner is held by the parent.
module ica_dca_burst_responder_rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // On a tie the client that did not win last time is picked.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    if (req == 2'b11) begin
      gnt_idx = ~last_grant;
    end else begin
      gnt_idx = req[1];
    end
  end

endmodule

// File: rtl/ica_dca_burst_responder.sv
// Burst responder: arbitrates two fetch units onto one memory burst port and
// returns each burst's words to the unit that requested it.
module ica_dca_burst_responder
  import ica_dca_burst_responder_pkg::*;
#(
  parameter int unsigned BURST_WORDS = BurstWordsDef,
  parameter int unsigned ADDR_W      = AddrWDef
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             c_as,
  input  logic [1:0][ADDR_W-1:0] c_address,
  output logic [15:0]            c_dout,
  output logic [1:0]             c_burstdata_valid,
  output logic [1:0]             c_bus_ack,
  output logic                   mem_req,
  output logic [ADDR_W-2:0]      mem_addr,
  input  logic                   mem_grant,
  input  logic [15:0]            mem_rdata,
  input  logic                   mem_rvalid
);

  localparam int unsigned CntW = $clog2(BURST_WORDS);
  localparam logic [CntW-1:0] LastCnt = CntW'(BURST_WORDS - 1);

  client_req_t [NumClients-1:0] reqs;
  logic gnt_valid, gnt_idx;

  resp_state_e          state_q, state_d;
  logic                 client_q, client_d;
  logic                 abort_q, abort_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 last_grant_q, last_grant_d;
  logic                 mem_req_q, mem_req_d;
  logic [ADDR_W-2:0]    mem_addr_q, mem_addr_d;
  logic [15:0]          dout_q, dout_d;
  logic [1:0]           valid_q, valid_d;
  logic [1:0]           ack_q, ack_d;
  logic                 abort_now;

  // Bundle the flat client ports into request records.
  always_comb begin
    for (int i = 0; i < NumClients; i++) begin
      reqs[i].as      = c_as[i];
      reqs[i].address = c_address[i];
    end
  end

  ica_dca_burst_responder_rr_arbiter2 u_arb (
    .req        ({reqs[1].as, reqs[0].as}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  // Next-state and output computation for the burst sequencer.
  always_comb begin
    state_d      = state_q;
    client_d     = client_q;
    abort_d      = abort_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    dout_d       = dout_q;
    valid_d      = '0;
    ack_d        = '0;
    // Once the owner lets go of c_as the rest of the burst is drained silently.
    abort_now    = abort_q | ~c_as[client_q];
    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          client_d   = gnt_idx;
          abort_d    = 1'b0;
          mem_req_d  = 1'b1;
          mem_addr_d = reqs[gnt_idx].address[ADDR_W-1:1];
          state_d    = StIssue;
        end
      end
      StIssue: begin
        abort_d = abort_now;
        if (mem_grant) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = StStream;
        end
      end
      StStream: begin
        abort_d = abort_now;
        if (mem_rvalid) begin
          dout_d = mem_rdata;
          cnt_d  = cnt_q + CntW'(1);
          if (!abort_now) valid_d[client_q] = 1'b1;
          if (cnt_q == LastCnt) begin
            last_grant_d = client_q;
            state_d      = StAck;
            if (!abort_now) ack_d[client_q] = 1'b1;
          end
        end
      end
      StAck: begin
        // Client swaps its request at this edge, so nothing is sampled here.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      client_q     <= 1'b0;
      abort_q      <= 1'b0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      dout_q       <= '0;
      valid_q      <= '0;
      ack_q        <= '0;
    end else begin
      state_q      <= state_d;
      client_q     <= client_d;
      abort_q      <= abort_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      dout_q       <= dout_d;
      valid_q      <= valid_d;
      ack_q        <= ack_d;
    end
  end

  // Simulation-only protocol sanity checks; hardware ignores both conditions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == StIdle && gnt_valid) begin
        assert (reqs[gnt_idx].address[1:0] == 2'b00)
          else $warning("client address not 32-bit aligned");
      end
      if (state_q != StStream) begin
        assert (!mem_rvalid) else $warning("mem_rvalid outside a burst ignored");
      end
    end
  end

  assign c_dout            = dout_q;
  assign c_burstdata_valid = valid_q;
  assign c_bus_ack         = ack_q;
  assign mem_req           = mem_req_q;
  assign mem_addr          = mem_addr_q;

endmodule

// File: tb/tb_ica_dca_burst_responder.sv
// Directed bench for the ICA/DCA burst responder.
module tb_ica_dca_burst_responder;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       c_as;
  logic [1:0][21:0] c_address;
  logic [15:0]      c_dout;
  logic [1:0]       c_burstdata_valid;
  logic [1:0]       c_bus_ack;
  logic             mem_req;
  logic [20:0]      mem_addr;
  logic             mem_grant;
  logic [15:0]      mem_rdata;
  logic             mem_rvalid;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ica_dca_burst_responder dut (
    .clk               (clk),
    .reset             (reset),
    .c_as              (c_as),
    .c_address         (c_address),
    .c_dout            (c_dout),
    .c_burstdata_valid (c_burstdata_valid),
    .c_bus_ack         (c_bus_ack),
    .mem_req           (mem_req),
    .mem_addr          (mem_addr),
    .mem_grant         (mem_grant),
    .mem_rdata         (mem_rdata),
    .mem_rvalid        (mem_rvalid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_dout"}, 32'(c_dout), 32'h0);
    check({tag, "_valid"}, 32'(c_burstdata_valid), 32'h0);
    check({tag, "_ack"}, 32'(c_bus_ack), 32'h0);
    check({tag, "_req"}, 32'(mem_req), 32'h0);
    check({tag, "_addr"}, 32'(mem_addr), 32'h0);
  endtask

  // Wait (bounded) for mem_req, check the word address, then grant it.
  task automatic issue(input string tag, input logic [20:0] exp_addr);
    int n = 0;
    while (mem_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, 32'(mem_req), 32'h1);
    check({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
    mem_grant = 1'b1;
    @(negedge clk);
    mem_grant = 1'b0;
    check({tag, "_reqdrop"}, 32'(mem_req), 32'h0);
  endtask

  // Return four words base*1..base*4; the client drops c_as after `keep` words.
  task automatic burst(input string tag, input bit cl, input logic [15:0] base, input int keep);
    logic [15:0] w;
    logic [1:0]  sel;
    for (int i = 0; i < 4; i++) begin
      w          = 16'(base * (i + 1));
      mem_rvalid = 1'b1;
      mem_rdata  = w;
      @(negedge clk);
      mem_rvalid = 1'b0;
      sel = (i < keep) ? (cl ? 2'b10 : 2'b01) : 2'b00;
      check($sformatf("%s_dout%0d", tag, i), 32'(c_dout), 32'(w));
      check($sformatf("%s_valid%0d", tag, i), 32'(c_burstdata_valid), 32'(sel));
      check($sformatf("%s_ack%0d", tag, i), 32'(c_bus_ack), (i == 3) ? 32'(sel) : 32'h0);
      if (i + 1 == keep && keep < 4) c_as[cl] = 1'b0;
    end
  endtask

  initial begin
    reset      = 1'b1;
    c_as       = 2'b00;
    c_address  = '0;
    mem_grant  = 1'b0;
    mem_rdata  = '0;
    mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("rst");

    // 1. Single burst from client 0.
    c_as[0] = 1'b1;
    c_address[0] = 22'h000400;
    issue("t1", 21'h000200);
    burst("t1", 1'b0, 16'h1111, 4);

    // 2. Client 0 releases after ack: no further request.
    c_as[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_noreq", 32'(mem_req), 32'h0);
      check("t2_novalid", 32'(c_burstdata_valid | c_bus_ack), 32'h0);
    end

    // 3. Contention from reset, three chained bursts each.
    reset = 1'b1;
    c_as  = 2'b11;
    c_address[0] = 22'h001000;
    c_address[1] = 22'h002000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bit cl;
      cl = bit'(k % 2);
      issue($sformatf("t3_b%0d", k), c_address[cl][21:1]);
      burst($sformatf("t3_b%0d", k), cl, 16'(16'h0101 * (k + 1)), 4);
      c_address[cl] = c_address[cl] + 22'd8;
      if (k >= 4) c_as[cl] = 1'b0;
    end

    // 4. Address not 64-bit aligned.
    c_as[0] = 1'b1;
    c_address[0] = 22'h000404;
    issue("t4", 21'h000202);
    burst("t4", 1'b0, 16'h0a0a, 4);
    c_as[0] = 1'b0;

    // 5. Client 1 aborts after two words; then client 0 is served.
    @(negedge clk);
    c_as[1] = 1'b1;
    c_address[1] = 22'h000800;
    issue("t5a", 21'h000400);
    burst("t5a", 1'b1, 16'h0202, 2);
    c_as[0] = 1'b1;
    c_address[0] = 22'h000600;
    issue("t5b", 21'h000300);
    burst("t5b", 1'b0, 16'h0303, 4);
    c_as[0] = 1'b0;

    // 6. Reset during a burst, stray memory words afterwards.
    @(negedge clk);
    c_as[1] = 1'b1;
    c_address[1] = 22'h000100;
    issue("t6a", 21'h000080);
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hbeef;
    @(negedge clk);
    check("t6_word1", 32'(c_burstdata_valid), 32'h2);
    reset      = 1'b1;
    c_as       = 2'b00;
    mem_rdata  = 16'hdead;
    @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("t6_rst");
    for (int i = 0; i < 2; i++) begin
      mem_rdata = 16'hcafe;
      @(negedge clk);
      check("t6_stray_valid", 32'(c_burstdata_valid | c_bus_ack), 32'h0);
      check("t6_stray_dout", 32'(c_dout), 32'h0);
      check("t6_stray_req", 32'(mem_req), 32'h0);
    end
    mem_rvalid = 1'b0;
    c_as[0] = 1'b1;
    c_address[0] = 22'h000040;
    issue("t6b", 21'h000020);
    burst("t6b", 1'b0, 16'h0404, 4);
    c_as[0] = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
